dma_xfer_engine: RTL
====================

Name: dma_xfer_engine

Overview:
- Initiator side of the go/dma_req/data_transfer burst protocol.
- On an accepted start it drives data_transfer high for a programmed, contiguous run of 1..256 words, with a word address and a completion strobe.
- Sits between the DMA request logic (go, dma_req) and the memory write port.
- Every transfer obeys: rose(go) with dma_req => data_transfer high from the next cycle for 1..256 consecutive cycles.

Parameters:
- ADDR_W, 16, width of base_addr and word_addr.
- LEN_W, 8, width of xfer_len_m1; burst length = xfer_len_m1+1, so max 2**LEN_W = 256 words.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- go  input  1  start request; only a 0->1 transition is significant.
- dma_req  input  1  DMA channel request; must be high in the cycle go rises.
- xfer_len_m1  input  LEN_W  burst length minus one; sampled at accept.
- base_addr  input  ADDR_W  first word address; sampled at accept.
- abort  input  1  terminate the current burst early.
- data_transfer  output  1  high for each word moved.
- word_addr  output  ADDR_W  address of the current word; valid while data_transfer=1.
- busy  output  1  burst in progress (equals data_transfer).
- done  output  1  one-cycle pulse after the last word or after an abort.
- aborted  output  1  qualifies done; 1 if the burst ended by abort.
- start_err  output  1  one-cycle pulse: go rose while dma_req=0.
- overrun  output  1  sticky: go rose while busy; cleared only by reset.

Behaviour:
- Edge detect: go_q registers go every cycle. rise = go & ~go_q. During reset, go_q loads go, so a go already high at reset release is not a rise.
- Reset values (next edge with reset=1): state IDLE; data_transfer, busy, done, aborted, start_err, overrun = 0; word_addr = 0; counter = 0.
- States: IDLE, XFER.
- IDLE, rise & dma_req at cycle t (accept):
  - Latch remaining = xfer_len_m1 and word_addr = base_addr.
  - Go to XFER; data_transfer=1 from cycle t+1 (one-cycle latency).
- IDLE, rise & ~dma_req: no transfer; start_err=1 at t+1 only; stay IDLE.
- XFER, each cycle:
  - If abort=1: go to IDLE; data_transfer drops the following cycle; done=1 and aborted=1 in that cycle. The cycle with abort high still counts as a transferred word.
  - Else if remaining==0 (last word): go to IDLE; next cycle data_transfer=0, done=1, aborted=0.
  - Else: remaining decrements by 1; word_addr increments by 1, mod 2**ADDR_W (wraps silently, no error).
- Burst length is exactly xfer_len_m1+1 cycles of data_transfer with no gaps. xfer_len_m1=0 gives 1 word; all-ones gives 256 words.
- go rise while in XFER: ignored for transfer purposes; overrun set to 1 at the next edge. dma_req changes during XFER are ignored.
- Back-to-back: a rise in the same cycle done is asserted (state already IDLE) is accepted normally. Minimum gap between bursts is one cycle (the done cycle).
- Simultaneous abort and last word: treated as abort (aborted=1), word count unchanged.
- Reset mid-burst: outputs return to reset values at that edge; no done pulse.
- xfer_len_m1 and base_addr are don't-care except at the accept cycle.

Test Plan:
- Reset, base_addr=16'h0100, xfer_len_m1=3, raise go with dma_req=1 at cycle 10 -> data_transfer high cycles 11-14; word_addr 0100..0103; done=1, aborted=0 at cycle 15.
- xfer_len_m1=8'hFF, base_addr=16'hFFFE, accept -> exactly 256 consecutive data_transfer cycles; word_addr FFFE, FFFF, 0000, ...; single done pulse.
- Raise go with dma_req=0 -> start_err pulses one cycle, data_transfer never asserts, busy stays 0; then toggle go low/high with dma_req=1 -> normal burst.
- Burst of 10 words, abort high on the 4th transfer cycle -> exactly 4 data_transfer cycles, then done=1 and aborted=1 together; raise go during the burst -> overrun=1 and held until reset.
- Hold go=1 through reset release -> no transfer. Start a 20-word burst and assert reset on its 5th cycle -> all outputs 0 at that edge, no done. Re-accept in the done cycle of a prior burst -> second burst starts one cycle after done.

Source files
------------

// File: rtl/dma_xfer_engine.sv
`default_nettype none
// ============================================================================
//  Module      : dma_xfer_engine
//  Description : Initiator side of the go/dma_req/data_transfer burst
//                protocol. An accepted rising edge of go starts a contiguous
//                run of xfer_len_m1+1 words with incrementing word address,
//                ending in a one-cycle done pulse (qualified by aborted).
//  Revision    : 1.0 - initial release
// ============================================================================
module dma_xfer_engine #(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic              dma_req,
    input  logic [LEN_W-1:0]  xfer_len_m1,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              abort,
    output logic              data_transfer,
    output logic [ADDR_W-1:0] word_addr,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              start_err,
    output logic              overrun
);

    localparam logic [ADDR_W-1:0] C_ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]  C_LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]  C_LEN_ZERO = '0;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_go_q;
    logic                w_rise;
    logic [LEN_W-1:0]    r_remaining;
    logic [LEN_W-1:0]    w_remaining_nxt;
    logic [ADDR_W-1:0]   r_word_addr;
    logic [ADDR_W-1:0]   w_word_addr_nxt;
    logic                r_done;
    logic                w_done_nxt;
    logic                r_aborted;
    logic                w_aborted_nxt;
    logic                r_start_err;
    logic                w_start_err_nxt;
    logic                r_overrun;
    logic                w_overrun_nxt;

    // Only a 0->1 transition of go is a start request.
    assign w_rise = go & ~r_go_q;

    // Track previous go; loads during reset too, so a go already high at
    // reset release is not seen as a new edge.
    always_ff @(posedge clk) begin
        r_go_q <= go;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_word_addr <= '0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
            r_start_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_word_addr <= w_word_addr_nxt;
            r_done      <= w_done_nxt;
            r_aborted   <= w_aborted_nxt;
            r_start_err <= w_start_err_nxt;
            r_overrun   <= w_overrun_nxt;
        end
    end

    // Next-state logic: accept in IDLE, count down words in XFER.
    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_word_addr_nxt = r_word_addr;
        w_done_nxt      = 1'b0;
        w_aborted_nxt   = 1'b0;
        w_start_err_nxt = 1'b0;
        w_overrun_nxt   = r_overrun;

        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    if (dma_req) begin
                        w_state_nxt     = ST_XFER;
                        w_remaining_nxt = xfer_len_m1;
                        w_word_addr_nxt = base_addr;
                    end else begin
                        w_start_err_nxt = 1'b1;
                    end
                end
            end
            ST_XFER: begin
                // A new request while a burst runs is flagged, never started.
                if (w_rise) begin
                    w_overrun_nxt = 1'b1;
                end
                // Abort takes priority over a simultaneous last word; the
                // current cycle still counts as a transferred word.
                if (abort) begin
                    w_state_nxt   = ST_IDLE;
                    w_done_nxt    = 1'b1;
                    w_aborted_nxt = 1'b1;
                end else if (r_remaining == C_LEN_ZERO) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_remaining_nxt = r_remaining - C_LEN_ONE;
                    w_word_addr_nxt = r_word_addr + C_ADDR_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign data_transfer = (r_state == ST_XFER);
    assign busy          = (r_state == ST_XFER);
    assign word_addr     = r_word_addr;
    assign done          = r_done;
    assign aborted       = r_aborted;
    assign start_err     = r_start_err;
    assign overrun       = r_overrun;

endmodule
`default_nettype wire
